// File: rtl/serial_eq_pkg.sv
// Shared types and sizing for the serial equality accumulator.
// Optional first-mismatch index output: SERIAL_EQ_FIRST_MM_EN.
package serial_eq_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int FRAME_LEN_DEF = 8;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_eq_accumulator_counter.sv
// Small up-counter with synchronous clear (priority) and enable.
// Width is set by the instantiating block.
module serial_eq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/serial_eq_accumulator.sv
// Serial N-bit comparator: folds per-bit eq results into a frame result.
// Optional res_first_mm port enabled by SERIAL_EQ_FIRST_MM_EN.
module serial_eq_accumulator
  import serial_eq_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = cnt_w(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             eq_in,
  input  logic             eq_valid,
  input  logic             eq_last,
  output logic             eq_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_match_cnt,
  output logic             res_all_eq,
  output logic             res_len_err
`ifdef SERIAL_EQ_FIRST_MM_EN
  ,
  output logic [CNT_W-1:0] res_first_mm
`endif
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(FRAME_LEN);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] bit_nxt;
  logic [CNT_W-1:0] match_nxt;
  logic             accept;
  logic             hs;
  logic             frame_end;
  logic             len_err_nxt;
  logic             st_accum;
  logic             st_done;

  assign st_accum  = (state == ACCUM);
  assign st_done   = (state == DONE);
  assign eq_ready  = st_accum;
  assign res_valid = st_done;

  assign accept    = eq_valid && eq_ready;
  assign hs        = res_valid && res_ready;
  assign bit_nxt   = bit_cnt + CNT_W'(1);
  assign match_nxt = match_cnt + CNT_W'(eq_in);

  // A frame closes on eq_last or when the full length is reached.
  assign frame_end   = accept && (eq_last || (bit_nxt == LEN_C));
  assign len_err_nxt = !(eq_last && (bit_nxt == LEN_C));

  serial_eq_counter #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hs),
    .en    (accept),
    .q     (bit_cnt)
  );

  serial_eq_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hs),
    .en    (accept && eq_in),
    .q     (match_cnt)
  );

`ifdef SERIAL_EQ_FIRST_MM_EN
  logic [CNT_W-1:0] mm_idx;
  logic [CNT_W-1:0] mm_nxt;

  assign mm_nxt = (accept && !eq_in && (mm_idx == LEN_C))
                ? bit_cnt : mm_idx;

  // LEN_C doubles as the "no mismatch yet" marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_idx       <= LEN_C;
      res_first_mm <= '0;
    end else begin
      if (hs) begin
        mm_idx <= LEN_C;
      end else begin
        mm_idx <= mm_nxt;
      end
      if (frame_end) begin
        res_first_mm <= mm_nxt;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACCUM;
      res_match_cnt <= '0;
      res_all_eq    <= 1'b0;
      res_len_err   <= 1'b0;
    end else begin
      unique case (1'b1)
        st_accum: begin
          if (frame_end) begin
            state         <= DONE;
            res_match_cnt <= match_nxt;
            res_len_err   <= len_err_nxt;
            res_all_eq    <= (match_nxt == bit_nxt) && !len_err_nxt;
          end
        end
        st_done: begin
          if (res_ready) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_eq_accumulator.sv
// Randomised self-checking bench for serial_eq_accumulator.
// Checks res_first_mm when SERIAL_EQ_FIRST_MM_EN is defined.
module tb_serial_eq_accumulator;

  localparam int FL    = 8;
  localparam int CNT_W = $clog2(FL + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             eq_in;
  logic             eq_valid;
  logic             eq_last;
  logic             eq_ready;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_match_cnt;
  logic             res_all_eq;
  logic             res_len_err;
`ifdef SERIAL_EQ_FIRST_MM_EN
  logic [CNT_W-1:0] res_first_mm;
`endif

  int checks   = 0;
  int failures = 0;

  serial_eq_accumulator #(.FRAME_LEN(FL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .eq_in         (eq_in),
    .eq_valid      (eq_valid),
    .eq_last       (eq_last),
    .eq_ready      (eq_ready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_match_cnt (res_match_cnt),
    .res_all_eq    (res_all_eq),
    .res_len_err   (res_len_err)
`ifdef SERIAL_EQ_FIRST_MM_EN
    ,
    .res_first_mm  (res_first_mm)
`endif
  );

  always #5 clk = ~clk;

  // Expected {match_cnt, all_eq, len_err} from the frame's bit list.
  function automatic logic [CNT_W+1:0] model(input logic [FL-1:0] b,
                                             input int n, input bit ul);
    int na = ul ? n : FL;
    int m  = 0;
    bit le;
    bit ae;
    for (int i = 0; i < na; i++) m += int'(b[i]);
    le = !(ul && n == FL);
    ae = (m == na) && !le;
    return {CNT_W'(m), ae, le};
  endfunction

  function automatic logic [CNT_W-1:0] model_mm(input logic [FL-1:0] b,
                                                input int n, input bit ul);
    int na = ul ? n : FL;
    for (int i = 0; i < na; i++)
      if (!b[i]) return CNT_W'(i);
    return CNT_W'(FL);
  endfunction

  // Starts and ends at a negedge; ok=0 on stall timeout or late result.
  task automatic send_frame(input logic [FL-1:0] b, input int n,
                            input bit ul, output bit ok);
    int nb = ul ? n : FL;
    int t;
    ok = 1'b1;
    for (int i = 0; i < nb; i++) begin
      eq_valid = 1'b1;
      eq_in    = b[i];
      eq_last  = ul && (i == nb - 1);
      t = 0;
      while (!eq_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    eq_valid = 1'b0;
    eq_in    = 1'bx;
    eq_last  = 1'bx;
    if (res_valid !== 1'b1) ok = 1'b0;
  endtask

  task automatic handshake(output bit ok);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    ok = (res_valid === 1'b0) && (eq_ready === 1'b1);
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    eq_valid  = 1'b0;
    eq_in     = 1'bx;
    eq_last   = 1'bx;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({eq_ready, res_valid, res_match_cnt, res_all_eq, res_len_err}
        !== {1'b1, 1'b0, CNT_W'(0), 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset got rdy=%b vld=%b cnt=%0d ae=%b le=%b",
               eq_ready, res_valid, res_match_cnt, res_all_eq, res_len_err);
    end
`ifdef SERIAL_EQ_FIRST_MM_EN
    checks++;
    if (res_first_mm !== CNT_W'(0)) begin
      failures++;
      $display("FAIL reset_first_mm got %0d want 0", res_first_mm);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame(input string nm, input logic [FL-1:0] b,
                            input int n, input bit ul);
    logic [CNT_W+1:0] exp;
    bit ok;
    exp = model(b, n, ul);
    send_frame(b, n, ul, ok);
    checks++;
    if (!ok || {res_match_cnt, res_all_eq, res_len_err} !== exp) begin
      failures++;
      $display("FAIL %s ok=%b got cnt=%0d ae=%b le=%b want cnt=%0d ae=%b le=%b",
               nm, ok, res_match_cnt, res_all_eq, res_len_err,
               exp[CNT_W+1:2], exp[1], exp[0]);
    end
`ifdef SERIAL_EQ_FIRST_MM_EN
    checks++;
    if (res_first_mm !== model_mm(b, n, ul)) begin
      failures++;
      $display("FAIL %s_first_mm got %0d want %0d", nm, res_first_mm,
               model_mm(b, n, ul));
    end
`endif
    handshake(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_handshake got vld=%b rdy=%b want vld=0 rdy=1",
               nm, res_valid, eq_ready);
    end
  endtask

  task automatic test_backpressure;
    logic [CNT_W+1:0] exp;
    logic [CNT_W+1:0] snap;
    bit ok;
    exp = model(8'hA5, FL, 1'b1);
    send_frame(8'hA5, FL, 1'b1, ok);
    checks++;
    if (!ok || {res_match_cnt, res_all_eq, res_len_err} !== exp) begin
      failures++;
      $display("FAIL bp_frame ok=%b got %h want %h", ok,
               {res_match_cnt, res_all_eq, res_len_err}, exp);
    end
    snap     = {res_match_cnt, res_all_eq, res_len_err};
    eq_valid = 1'b1;
    eq_in    = 1'b0;
    eq_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (eq_ready !== 1'b0 || res_valid !== 1'b1 ||
          {res_match_cnt, res_all_eq, res_len_err} !== snap) begin
        failures++;
        $display("FAIL bp_stall c=%0d rdy=%b vld=%b got %h want %h", c,
                 eq_ready, res_valid,
                 {res_match_cnt, res_all_eq, res_len_err}, snap);
      end
    end
    handshake(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_handshake got vld=%b rdy=%b", res_valid, eq_ready);
    end
    test_frame("bp_next", 8'hFE, FL, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      eq_valid = 1'b1;
      eq_in    = 1'b1;
      eq_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    eq_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || eq_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid got vld=%b rdy=%b want vld=0 rdy=1",
               res_valid, eq_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_frame("after_reset", 8'hFF, FL, 1'b1);
  endtask

  task automatic test_random;
    logic [FL-1:0] b;
    int n;
    bit ul;
    for (int f = 0; f < 30; f++) begin
      b  = FL'($urandom);
      ul = ($urandom_range(0, 3) != 0);
      n  = ul ? int'($urandom_range(2, FL)) : FL;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      test_frame("random", b, n, ul);
    end
  endtask

  initial begin
    test_reset();
    test_frame("all_match", 8'hFF, FL, 1'b1);
    test_frame("pattern", 8'hBB, FL, 1'b1);
    test_frame("short", 8'hFF, 5, 1'b1);
    test_frame("no_last", 8'h3C, FL, 1'b0);
    test_frame("after_no_last", 8'hFF, FL, 1'b1);
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
